// File: rtl/hamming_pkg.sv
// Shared types and defaults for the Hamming check sequencer.
// Holds the FSM state type, digit slots and parameter defaults.
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPTURE,
    DONE
  } state_e;

  typedef logic [1:0] digit_t;

  localparam digit_t DIG_DATA = 2'd0;
  localparam digit_t DIG_CORR = 2'd1;
  localparam digit_t DIG_SYN  = 2'd2;
  localparam digit_t DIG_ERR  = 2'd3;

  localparam int DEF_SETTLE_CYC  = 2;
  localparam int DEF_REFRESH_DIV = 27000;
  localparam int DEF_BLANK_CYC   = 1;

endpackage

// File: rtl/hamming_seq_ctrl_scan_mux.sv
// Free-running four-digit display scanner.
// Owns the refresh counter, digit index and anode enables.
module scan_mux
  import hamming_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLANK_CYC   = DEF_BLANK_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  output digit_t     dig_nxt_o,
  output logic [3:0] an_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_t        dig_q, dig_d;
  logic [3:0]    an_q, an_d;

  // Next counter/digit; anodes decoded from next state so they stay registered
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end
    an_d = 4'b1111;
    if (cnt_d >= CNT_BLANK) an_d[dig_d] = 1'b0;
  end

  // Scan state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dig_q <= DIG_DATA;
      an_q  <= 4'b1111;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      an_q  <= an_d;
    end
  end

  assign dig_nxt_o = dig_d;
  assign an_o      = an_q;

endmodule

// File: rtl/hamming_seq_ctrl.sv
// Sequencer for an external Hamming(7,4) checker.
// Latches a word, waits for settle, captures results, drives display.
module hamming_seq_ctrl
  import hamming_pkg::*;
#(
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLANK_CYC   = DEF_BLANK_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] i,
  input  logic [6:0] e,
  input  logic [2:0] syn,
  input  logic [3:0] corr,
  output logic [6:0] cw,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] seg_val,
  output logic [3:0] an
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [6:0] cw_q;
  logic [3:0] i_hold_q;
  logic [3:0] corr_hold_q;
  logic [2:0] syn_hold_q;
  logic       err_q;
  logic [3:0] seg_val_q, seg_val_d;
  digit_t     dig_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start outside IDLE is dropped
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SETTLE;
      SETTLE:  if (scnt_q == SETTLE_LAST) state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == LOAD),
      (state_q == SETTLE),
      (state_q == CAPTURE): busy = 1'b1;
      (state_q == DONE):    done = 1'b1;
      default: ;
    endcase
  end

  // Settle counter restarts in LOAD, runs during SETTLE
  always_comb begin
    scnt_d = scnt_q;
    if (state_q == LOAD)   scnt_d = '0;
    if (state_q == SETTLE) scnt_d = scnt_q + 4'd1;
  end

  // Word latch in LOAD, atomic result capture in CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q      <= '0;
      cw_q        <= '0;
      i_hold_q    <= '0;
      corr_hold_q <= '0;
      syn_hold_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      scnt_q <= scnt_d;
      if (state_q == LOAD) begin
        cw_q     <= e;
        i_hold_q <= i;
      end
      if (state_q == CAPTURE) begin
        corr_hold_q <= corr;
        syn_hold_q  <= syn;
        err_q       <= |syn;
      end
    end
  end

  // Display value for the digit that becomes active next cycle
  always_comb begin
    seg_val_d = '0;
    unique case (dig_nxt)
      DIG_DATA: seg_val_d = i_hold_q;
      DIG_CORR: seg_val_d = corr_hold_q;
      DIG_SYN:  seg_val_d = {1'b0, syn_hold_q};
      DIG_ERR:  seg_val_d = {3'b000, err_q};
    endcase
  end

  // Registered display value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_val_q <= '0;
    else        seg_val_q <= seg_val_d;
  end

  scan_mux #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLANK_CYC  (BLANK_CYC)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .dig_nxt_o(dig_nxt),
    .an_o     (an)
  );

  assign cw      = cw_q;
  assign err     = err_q;
  assign seg_val = seg_val_q;

endmodule
